// File: rtl/seg7_clock_hms_if.sv
// rtl/seg7_clock_hms_if.sv - key inputs and seven-segment outputs of the HH:MM:SS clock
interface seg7_clock_hms_if;
   logic       key_mode;
   logic       key_inc;
   logic [6:0] hex0;
   logic [6:0] hex1;
   logic [6:0] hex2;
   logic [6:0] hex3;
   logic [6:0] hex4;
   logic [6:0] hex5;
   logic [1:0] mode_o;
   logic       tick;

   modport master (
      output key_mode, key_inc,
      input  hex0, hex1, hex2, hex3, hex4, hex5, mode_o, tick
   );

   modport slave (
      input  key_mode, key_inc,
      output hex0, hex1, hex2, hex3, hex4, hex5, mode_o, tick
   );
endinterface

// File: rtl/seg7_clock_hms.sv
// rtl/seg7_clock_hms.sv - six-digit HH:MM:SS clock with set-time FSM and blinking digits
// Time is kept as packed BCD bytes; every HEX output is registered from the current state.
module seg7_clock_hms #(
   parameter int CLK_HZ     = 50_000_000,
   parameter int HOUR24     = 1,
   parameter int ACTIVE_LOW = 1
) (
   input logic             clk,
   input logic             rst,
   seg7_clock_hms_if.slave bus
);
   localparam int            CW       = $clog2(CLK_HZ);
   localparam logic [CW-1:0] CNT_LAST = CW'(CLK_HZ - 1);
   localparam logic [CW-1:0] CNT_HALF = CW'(CLK_HZ / 2);
   localparam bit            H24      = (HOUR24 != 0);
   localparam logic [7:0]    HR_RST   = H24 ? 8'h00 : 8'h12;

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      SET_HOUR = 2'd1,
      SET_MIN  = 2'd2
   } state_t;

   state_t        state;
   logic [CW-1:0] cnt;
   logic [7:0]    secs;
   logic [7:0]    mins;
   logic [7:0]    hrs;
   logic [6:0]    hex_q [0:5];

   logic [1:0]    mode_sync;
   logic [1:0]    inc_sync;
   logic          mode_last;
   logic          inc_last;
   logic          mode_armed;
   logic          inc_armed;
   logic          mode_edge;
   logic          inc_edge;
   logic [1:0]    settle;

   logic          tick_w;
   logic          phase_on;
   logic          blank_hr;
   logic          blank_min;
   logic          hr_tens_blank;

   function automatic logic [7:0] bcd_inc(input logic [7:0] v);
      if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'd0};
      return {v[7:4], v[3:0] + 4'd1};
   endfunction

   function automatic logic [7:0] sixty_inc(input logic [7:0] v);
      if (v == 8'h59) return 8'h00;
      return bcd_inc(v);
   endfunction

   function automatic logic [7:0] hour_inc(input logic [7:0] h);
      if (H24 && h == 8'h23) return 8'h00;
      if (!H24 && h == 8'h12) return 8'h01;
      return bcd_inc(h);
   endfunction

   function automatic logic [6:0] seg7(input logic [3:0] d, input logic blank);
      logic [6:0] p;
      if (blank) begin
         p = 7'h7F;
      end else begin
         case (d)
            4'd0:    p = 7'b1000000;
            4'd1:    p = 7'b1111001;
            4'd2:    p = 7'b0100100;
            4'd3:    p = 7'b0110000;
            4'd4:    p = 7'b0011001;
            4'd5:    p = 7'b0010010;
            4'd6:    p = 7'b0000010;
            4'd7:    p = 7'b1011000;
            4'd8:    p = 7'b0000000;
            4'd9:    p = 7'b0010000;
            default: p = 7'h7F;
         endcase
      end
      return (ACTIVE_LOW != 0) ? p : ~p;
   endfunction

   assign tick_w        = (cnt == CNT_LAST);
   assign phase_on      = (cnt < CNT_HALF);
   assign blank_hr      = (state == SET_HOUR) && !phase_on;
   assign blank_min     = (state == SET_MIN) && !phase_on;
   assign hr_tens_blank = !H24 && (hrs[7:4] == 4'd0);

   // A key must be seen low after reset before it may produce an edge, so a key
   // held through reset stays inert until it is released and pressed again.
   always_ff @(posedge clk) begin
      if (rst) begin
         mode_sync  <= 2'b00;
         inc_sync   <= 2'b00;
         mode_last  <= 1'b0;
         inc_last   <= 1'b0;
         mode_armed <= 1'b0;
         inc_armed  <= 1'b0;
         mode_edge  <= 1'b0;
         inc_edge   <= 1'b0;
         settle     <= 2'b00;
      end else begin
         mode_sync  <= {mode_sync[0], bus.key_mode};
         inc_sync   <= {inc_sync[0], bus.key_inc};
         mode_last  <= mode_sync[1];
         inc_last   <= inc_sync[1];
         settle     <= {settle[0], 1'b1};
         mode_armed <= mode_armed | (settle[1] & ~mode_sync[1]);
         inc_armed  <= inc_armed | (settle[1] & ~inc_sync[1]);
         mode_edge  <= mode_sync[1] & ~mode_last & mode_armed;
         inc_edge   <= inc_sync[1] & ~inc_last & inc_armed;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= RUN;
         cnt      <= '0;
         secs     <= 8'h00;
         mins     <= 8'h00;
         hrs      <= HR_RST;
         hex_q[5] <= seg7(HR_RST[7:4], !H24 && (HR_RST[7:4] == 4'd0));
         hex_q[4] <= seg7(HR_RST[3:0], 1'b0);
         hex_q[3] <= seg7(4'd0, 1'b0);
         hex_q[2] <= seg7(4'd0, 1'b0);
         hex_q[1] <= seg7(4'd0, 1'b0);
         hex_q[0] <= seg7(4'd0, 1'b0);
      end else begin
         cnt <= tick_w ? '0 : cnt + 1'b1;

         case (state)
            RUN: begin
               if (mode_edge) state <= SET_HOUR;
               if (tick_w) begin
                  secs <= sixty_inc(secs);
                  if (secs == 8'h59) begin
                     mins <= sixty_inc(mins);
                     if (mins == 8'h59) hrs <= hour_inc(hrs);
                  end
               end
            end
            SET_HOUR: begin
               if (mode_edge)     state <= SET_MIN;
               else if (inc_edge) hrs   <= hour_inc(hrs);
            end
            SET_MIN: begin
               // Leaving set mode restarts the second cleanly from its beginning.
               if (mode_edge) begin
                  state <= RUN;
                  secs  <= 8'h00;
                  cnt   <= '0;
               end else if (inc_edge) begin
                  mins  <= sixty_inc(mins);
               end
            end
            default: state <= RUN;
         endcase

         hex_q[5] <= seg7(hrs[7:4], blank_hr || hr_tens_blank);
         hex_q[4] <= seg7(hrs[3:0], blank_hr);
         hex_q[3] <= seg7(mins[7:4], blank_min);
         hex_q[2] <= seg7(mins[3:0], blank_min);
         hex_q[1] <= seg7(secs[7:4], 1'b0);
         hex_q[0] <= seg7(secs[3:0], 1'b0);
      end
   end

   assign bus.hex0   = hex_q[0];
   assign bus.hex1   = hex_q[1];
   assign bus.hex2   = hex_q[2];
   assign bus.hex3   = hex_q[3];
   assign bus.hex4   = hex_q[4];
   assign bus.hex5   = hex_q[5];
   assign bus.mode_o = state;
   assign bus.tick   = tick_w;
endmodule
